// File: rtl/miter_pkg.sv
// miter_pkg: shared types and limits for the sequential miter monitor
package miter_pkg;
  typedef enum logic [2:0] {IDLE, WARMUP, CHECK, PASS, FAIL} state_t;
  localparam int MAX_DELAY = 7;
  typedef enum logic {CMP_EQUAL, CMP_DIFF} cmp_t;
endpackage

// File: rtl/sample_delay_line.sv
// sample_delay_line: enabled shift register with sync clear; DEPTH=0 degenerates to a wire
module sample_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst_n, clr, en};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] r [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r <= '{default: '0};
      else if (clr) r <= '{default: '0};
      else if (en) begin
        r[0] <= d;
        for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
      end
    assign q = r[DEPTH-1];
  end
endmodule

// File: rtl/seq_miter_monitor.sv
// seq_miter_monitor: aligns two circuit outputs and issues a sticky bounded-equivalence verdict
module seq_miter_monitor import miter_pkg::*; #(
  parameter int WIDTH   = 1,
  parameter int DELAY_A = 0,
  parameter int DELAY_B = 0,
  parameter int WARM    = 1,
  parameter int BOUND   = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             valid,
  input  logic [WIDTH-1:0] out_a,
  input  logic [WIDTH-1:0] out_b,
  output logic             busy,
  output logic             done,
  output logic             equiv,
  output logic [CNT_W-1:0] fail_cycle,
  output logic [WIDTH-1:0] fail_bits
);
  if (DELAY_A > MAX_DELAY || DELAY_B > MAX_DELAY || WARM < DELAY_A || WARM < DELAY_B || BOUND < 1)
    begin : g_bad_params
      $error("seq_miter_monitor: illegal parameter combination");
    end
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, fail_cycle_n;
  logic [WIDTH-1:0] a_q, b_q, diff, fail_bits_n;
  logic clr;
  cmp_t cmp;
  sample_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY_A)) u_dly_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(valid), .d(out_a), .q(a_q));
  sample_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY_B)) u_dly_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(valid), .d(out_b), .q(b_q));
  assign diff = a_q ^ b_q;
  // case matching sends an unknown compare to the mismatch arm
  always_comb
    case (~|diff)
      1'b1:    cmp = CMP_EQUAL;
      default: cmp = CMP_DIFF;
    endcase
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    fail_cycle_n = fail_cycle;
    fail_bits_n  = fail_bits;
    clr          = 1'b0;
    if (abort) begin
      state_n      = IDLE;
      cnt_n        = '0;
      fail_cycle_n = '0;
      fail_bits_n  = '0;
      clr          = 1'b1;
    end else if (start && (state == IDLE || state == PASS || state == FAIL)) begin
      state_n      = WARM > 0 ? WARMUP : CHECK;
      cnt_n        = '0;
      fail_cycle_n = '0;
      fail_bits_n  = '0;
      clr          = 1'b1;
    end else if (valid && state == WARMUP) begin
      state_n = cnt == CNT_W'(WARM - 1) ? CHECK : WARMUP;
      cnt_n   = cnt == CNT_W'(WARM - 1) ? '0 : cnt + CNT_W'(1);
    end else if (valid && state == CHECK) begin
      if (cmp == CMP_DIFF) begin
        state_n      = FAIL;
        fail_cycle_n = cnt;
        fail_bits_n  = diff;
      end else if (cnt == CNT_W'(BOUND - 1)) state_n = PASS;
      else cnt_n = cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      fail_cycle <= '0;
      fail_bits  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      fail_cycle <= fail_cycle_n;
      fail_bits  <= fail_bits_n;
    end
  assign busy  = state == WARMUP || state == CHECK;
  assign done  = state == PASS || state == FAIL;
  assign equiv = state == PASS;
endmodule

// File: tb/tb_seq_miter_monitor.sv
// tb_seq_miter_monitor: randomized runs against a sample-array reference with a verdict scoreboard
module tb_seq_miter_monitor;
  localparam int W = 4, DA = 2, DB = 1, WM = 3, BD = 5, CW = 8;
  logic clk = 0, rst_n = 1, start = 0, abort = 0, valid = 0;
  logic [W-1:0] out_a = '0, out_b = '0;
  logic busy, done, equiv;
  logic [CW-1:0] fail_cycle;
  logic [W-1:0] fail_bits;
  typedef struct {logic eq; int fc; logic [W-1:0] fb;} verdict_t;
  verdict_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic done_q = 0;

  always #5 clk = ~clk;

  seq_miter_monitor #(.WIDTH(W), .DELAY_A(DA), .DELAY_B(DB), .WARM(WM), .BOUND(BD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
    .out_a(out_a), .out_b(out_b), .busy(busy), .done(done), .equiv(equiv),
    .fail_cycle(fail_cycle), .fail_bits(fail_bits));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every rising DONE must match the oldest predicted verdict
  always @(negedge clk) begin
    verdict_t v;
    if (rst_n && done && !done_q) begin
      chk("done_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        v = sb.pop_front();
        chk("equiv", equiv, v.eq);
        chk("fail_cycle", fail_cycle, v.fc);
        chk("fail_bits", fail_bits, v.fb);
      end
    end
    done_q = done;
  end

  // err_at: -2 clean, -1 random corruption, >=0 corrupt only that check index
  task automatic run(input int err_at, input bit do_abort);
    logic [W-1:0] as[$], bs[$];
    logic [W-1:0] a, b, aa, ab;
    int k = 0, j, guard = 0, abort_at;
    bit decided = 0, ab_now, inj;
    abort_at = do_abort ? int'($urandom_range(0, WM + BD - 1)) : -1;
    start = 1; valid = 1'($urandom); out_a = W'($urandom); out_b = W'($urandom);
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    while (!decided && guard < 200) begin
      guard++;
      valid = ($urandom % 4) != 0;
      start = ($urandom % 8) == 0;
      ab_now = valid && k == abort_at;
      abort = ab_now;
      a = W'($urandom);
      b = (k == 0) ? W'($urandom) : as[k-1];
      inj = (err_at == -1) ? ($urandom % 6 == 0) : (err_at >= 0 && k == WM + err_at - DB);
      if (inj) b ^= W'($urandom_range(1, (1 << W) - 1));
      out_a = a; out_b = b;
      if (valid && !ab_now) begin
        as.push_back(a); bs.push_back(b);
        if (k >= WM) begin
          j = k - WM;
          aa = k >= DA ? as[k-DA] : '0;
          ab = k >= DB ? bs[k-DB] : '0;
          if (aa != ab) begin sb.push_back('{1'b0, j, aa ^ ab}); decided = 1; end
          else if (j == BD - 1) begin sb.push_back('{1'b1, 0, '0}); decided = 1; end
        end
      end
      @(negedge clk);
      abort = 0; start = 0;
      if (ab_now) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_fail_cycle", fail_cycle, 0);
        valid = 0;
        return;
      end
      if (valid) k++;
      chk(decided ? "done_on_verdict" : "busy_running", decided ? done : busy, 1);
    end
    chk("run_decided", int'(decided), 1);
    valid = 0;
    repeat (2) @(negedge clk);
    chk("verdict_held", done, 1);
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_equiv", equiv, 0);
    chk("rst_fail_cycle", fail_cycle, 0);
    chk("rst_fail_bits", fail_bits, 0);
    @(negedge clk); rst_n = 1; @(negedge clk);
    run(-2, 0);
    run(0, 0);
    run(BD - 1, 0);
    run(2, 0);
    repeat (40) run(-1, ($urandom % 4) == 0);
    start = 1; @(negedge clk); start = 0;
    valid = 1; out_a = '0; out_b = '0;
    repeat (WM + 2) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_equiv", equiv, 0);
    valid = 0;
    @(negedge clk); rst_n = 1; @(negedge clk);
    run(-2, 0);
    run(1, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
